// File: rtl/dmem_pkg.sv
// Shared constants, FSM state type and byte-merge helper for the data-memory responder.
package dmem_pkg;

  localparam int unsigned DMEM_ADDR_W = 8;
  localparam int unsigned DMEM_DATA_W = 32;
  localparam int unsigned DMEM_STRB_W = 4;
  localparam int unsigned DMEM_DEPTH  = 256;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StAck,
    StClear
  } dmem_state_t;

  // Strobed bytes come from wdata, the rest from the old word.
  function automatic logic [DMEM_DATA_W-1:0] merge_bytes(
    input logic [DMEM_DATA_W-1:0] old_word,
    input logic [DMEM_DATA_W-1:0] wdata,
    input logic [DMEM_STRB_W-1:0] strb
  );
    logic [DMEM_DATA_W-1:0] res;
    res = old_word;
    for (int i = 0; i < int'(DMEM_STRB_W); i++) begin
      if (strb[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// MEM-stage memory port: four-phase mreq/mres handshake with address, strobes and data.
interface dmem_if;
  import dmem_pkg::*;

  logic                   mreq;
  logic [DMEM_ADDR_W-1:0] addr_mem;
  logic [DMEM_STRB_W-1:0] w_mem;
  logic [DMEM_DATA_W-1:0] store_data;
  logic [DMEM_DATA_W-1:0] load_data;
  logic                   mres;

  modport master (
    output mreq, addr_mem, w_mem, store_data,
    input  load_data, mres
  );

  modport slave (
    input  mreq, addr_mem, w_mem, store_data,
    output load_data, mres
  );
endinterface

// File: rtl/dmem_array.sv
// Single-port 256 x 32 RAM with per-byte write enable and registered (read-first) read data.
module dmem_array
  import dmem_pkg::*;
(
  input  logic                   clk,
  input  logic [DMEM_STRB_W-1:0] wen,
  input  logic [DMEM_ADDR_W-1:0] addr,
  input  logic [DMEM_DATA_W-1:0] wdata,
  output logic [DMEM_DATA_W-1:0] rdata
);

  logic [DMEM_DATA_W-1:0] mem [DMEM_DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(DMEM_STRB_W); i++) begin
      if (wen[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with programmable access latency.
// Optional DMEM_CLEAR_EN: zero-fill sweep of the whole array after reset.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned LATENCY = 2
) (
  input logic   clk,
  input logic   rst,
  dmem_if.slave bus
);

`ifdef DMEM_CLEAR_EN
  localparam dmem_state_t RstState = StClear;
`else
  localparam dmem_state_t RstState = StIdle;
`endif

  dmem_state_t            state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [DMEM_ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DMEM_STRB_W-1:0] req_strb_q, req_strb_d;
  logic [DMEM_DATA_W-1:0] req_data_q, req_data_d;
  logic [DMEM_DATA_W-1:0] load_data_q, load_data_d;
  logic                   mres_q, mres_d;
`ifdef DMEM_CLEAR_EN
  logic [DMEM_ADDR_W-1:0] clr_addr_q, clr_addr_d;
`endif

  logic [DMEM_STRB_W-1:0] ram_wen;
  logic [DMEM_ADDR_W-1:0] ram_addr;
  logic [DMEM_DATA_W-1:0] ram_wdata;
  logic [DMEM_DATA_W-1:0] ram_rdata;
  logic [DMEM_DATA_W-1:0] merged;

  // The RAM is addressed at the request address from acceptance onward, so by the access edge
  // ram_rdata holds the old word and the post-write word can be formed without a second read.
  assign merged = merge_bytes(ram_rdata, req_data_q, req_strb_q);

  dmem_array u_array (
    .clk   (clk),
    .wen   (ram_wen),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_addr_d  = req_addr_q;
    req_strb_d  = req_strb_q;
    req_data_d  = req_data_q;
    load_data_d = load_data_q;
    mres_d      = mres_q;
    ram_wen     = '0;
    ram_addr    = req_addr_q;
    ram_wdata   = merged;
`ifdef DMEM_CLEAR_EN
    clr_addr_d  = clr_addr_q;
`endif
    case (state_q)
      StIdle: begin
        ram_addr = bus.addr_mem;
        if (bus.mreq) begin
          req_addr_d = bus.addr_mem;
          req_strb_d = bus.w_mem;
          req_data_d = bus.store_data;
          cnt_d      = 4'(LATENCY - 1);
          state_d    = StWait;
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          ram_wen     = req_strb_q;
          load_data_d = merged;
          mres_d      = 1'b1;
          state_d     = StAck;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StAck: begin
        if (!bus.mreq) begin
          mres_d  = 1'b0;
          state_d = StIdle;
        end
      end
`ifdef DMEM_CLEAR_EN
      StClear: begin
        ram_addr   = clr_addr_q;
        ram_wen    = '1;
        ram_wdata  = '0;
        clr_addr_d = clr_addr_q + 8'd1;
        if (clr_addr_q == 8'hFF) state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
    // Reset wins: a pending access must not reach the array.
    if (rst) ram_wen = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RstState;
      cnt_q       <= '0;
      req_addr_q  <= '0;
      req_strb_q  <= '0;
      req_data_q  <= '0;
      load_data_q <= '0;
      mres_q      <= 1'b0;
`ifdef DMEM_CLEAR_EN
      clr_addr_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_addr_q  <= req_addr_d;
      req_strb_q  <= req_strb_d;
      req_data_q  <= req_data_d;
      load_data_q <= load_data_d;
      mres_q      <= mres_d;
`ifdef DMEM_CLEAR_EN
      clr_addr_q  <= clr_addr_d;
`endif
    end
  end

  assign bus.load_data = load_data_q;
  assign bus.mres      = mres_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed testbench for dmem_responder with LATENCY=2; the clear-sweep checks build only
// when DMEM_CLEAR_EN is defined.
module tb_dmem_responder;

  localparam int unsigned Lat = 2;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  dmem_if bus ();

  dmem_responder #(.LATENCY(Lat)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full handshake from IDLE: raise mreq, wait for mres, drop mreq, check release.
  task automatic run_txn(input string tag, input logic [7:0] addr, input logic [3:0] strb,
                         input logic [31:0] data, output logic [31:0] ld);
    int cyc;
    bus.mreq       = 1'b1;
    bus.addr_mem   = addr;
    bus.w_mem      = strb;
    bus.store_data = data;
    cyc = 0;
    tick();
    while (bus.mres !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    check_eq({tag, "_latency"}, 32'(cyc), 32'(Lat));
    ld = bus.load_data;
    bus.mreq  = 1'b0;
    bus.w_mem = 4'h0;
    tick();
    check_eq({tag, "_release"}, 32'(bus.mres), 32'd0);
  endtask

  logic [31:0] ld;

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    rst            = 1'b1;
    bus.mreq       = 1'b0;
    bus.addr_mem   = '0;
    bus.w_mem      = '0;
    bus.store_data = '0;
    tick();
    tick();
    rst = 1'b0;
    check_eq("rst_mres", 32'(bus.mres), 32'd0);
    check_eq("rst_load", bus.load_data, 32'h0);

    // Full write, latency observed edge by edge, then mreq held through ACK.
    bus.mreq       = 1'b1;
    bus.addr_mem   = 8'h10;
    bus.w_mem      = 4'hF;
    bus.store_data = 32'hDEADBEEF;
    tick();
    check_eq("wr_e0_mres", 32'(bus.mres), 32'd0);
    tick();
    check_eq("wr_e1_mres", 32'(bus.mres), 32'd0);
    tick();
    check_eq("wr_e2_mres", 32'(bus.mres), 32'd1);
    check_eq("wr_e2_load", bus.load_data, 32'hDEADBEEF);
    bus.store_data = 32'h11111111;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("hold_mres", 32'(bus.mres), 32'd1);
      check_eq("hold_load", bus.load_data, 32'hDEADBEEF);
    end
    bus.mreq = 1'b0;
    tick();
    check_eq("drop_mres", 32'(bus.mres), 32'd0);
    check_eq("drop_load_kept", bus.load_data, 32'hDEADBEEF);

    run_txn("rd10", 8'h10, 4'h0, 32'h0, ld);
    check_eq("rd10_data", ld, 32'hDEADBEEF);

    // Strobe merging, including a non-contiguous pattern.
    run_txn("wb0", 8'h10, 4'b0001, 32'h000000AA, ld);
    check_eq("wb0_data", ld, 32'hDEADBEAA);
    run_txn("wb2", 8'h10, 4'b0100, 32'h00CC0000, ld);
    check_eq("wb2_data", ld, 32'hDECCBEAA);
    run_txn("rdm", 8'h10, 4'h0, 32'hFFFFFFFF, ld);
    check_eq("rdm_data", ld, 32'hDECCBEAA);
    run_txn("w30", 8'h30, 4'hF, 32'h01234567, ld);
    run_txn("wnc", 8'h30, 4'b1010, 32'hAABBCCDD, ld);
    check_eq("wnc_data", ld, 32'hAA23CC67);
    run_txn("r30", 8'h30, 4'h0, 32'h0, ld);
    check_eq("r30_data", ld, 32'hAA23CC67);

    // Reset on the access edge of a write: write must not happen.
    run_txn("w20", 8'h20, 4'hF, 32'h0BADF00D, ld);
    bus.mreq       = 1'b1;
    bus.addr_mem   = 8'h20;
    bus.w_mem      = 4'hF;
    bus.store_data = 32'h12345678;
    tick();
    tick();
    rst      = 1'b1;
    bus.mreq = 1'b0;
    tick();
    rst = 1'b0;
    check_eq("rstw_mres", 32'(bus.mres), 32'd0);
    check_eq("rstw_load", bus.load_data, 32'h0);
    run_txn("r20", 8'h20, 4'h0, 32'h0, ld);
    check_eq("r20_data", ld, 32'h0BADF00D);

    // mreq dropped during WAIT: access still completes, mres pulses one cycle.
    bus.mreq       = 1'b1;
    bus.addr_mem   = 8'h40;
    bus.w_mem      = 4'hF;
    bus.store_data = 32'h55AA55AA;
    tick();
    bus.mreq = 1'b0;
    tick();
    check_eq("viol_e1_mres", 32'(bus.mres), 32'd0);
    tick();
    check_eq("viol_e2_mres", 32'(bus.mres), 32'd1);
    check_eq("viol_e2_load", bus.load_data, 32'h55AA55AA);
    tick();
    check_eq("viol_e3_mres", 32'(bus.mres), 32'd0);

`ifdef DMEM_CLEAR_EN
    begin
      int cyc;
      bus.mreq       = 1'b1;
      bus.addr_mem   = 8'hFF;
      bus.w_mem      = 4'h0;
      bus.store_data = 32'h0;
      rst            = 1'b1;
      tick();
      rst = 1'b0;
      cyc = 0;
      while (bus.mres !== 1'b1 && cyc < 400) begin
        tick();
        cyc++;
      end
      // 256 sweep edges, one IDLE acceptance edge, then LATENCY.
      check_eq("clr_latency", 32'(cyc), 32'(256 + 1 + Lat));
      check_eq("clr_rdff", bus.load_data, 32'h0);
      bus.mreq = 1'b0;
      tick();
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
